// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the RV32I pipeline.
//
// Accepts one EXE result at a time (in_valid/in_ready). Loads and stores are
// run on a req/gnt/rvalid data-memory bus. Every other op completes one cycle
// after accept. This covers non-memory ops, branch-only ops, and memory ops
// that are misaligned or use an illegal funct3. Each accepted op produces
// exactly one registered wb_valid pulse carrying the MEM/WB results.
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. A bus request is accepted on a rising edge
// where dmem_req && dmem_gnt. Read data is taken on a rising edge with
// dmem_rvalid, but only while waiting for it (WAIT_R).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid / in_ready         upstream handshake
//   crt_mem_in                  [0]=mem_read [1]=mem_write [2]=branch
//   crt_wb_in, funct3_in        write-back control, access size/sign
//   alu_result_in               address or ALU result
//   store_data_in               rs2 data for stores
//   rd_in, zero_in              destination register, ALU zero flag
//   pc_target_in                branch target
//   dmem_*                      data-memory bus
//   wb_valid, crt_wb_out,
//   wb_data, rd_out             registered MEM/WB results
//   pc_src_out, pc_target_out   branch decision and target
//   misalign_out, bus_err_out   error flags, valid with wb_valid
//   stall_out                   high while an access is in flight
module mem_stage #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  crt_mem_in,
    input  logic [1:0]  crt_wb_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic        zero_in,
    input  logic [31:0] pc_target_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [1:0]  crt_wb_out,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        pc_src_out,
    output logic [31:0] pc_target_out,
    output logic        misalign_out,
    output logic        bus_err_out,
    output logic        stall_out
);

    // The counter only has to reach BUS_TIMEOUT-1. The access aborts on the
    // edge that would complete the BUS_TIMEOUT-th cycle in REQ or WAIT_R.
    localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   alu_q;     // full address, kept for lane select and wb_data
    logic [2:0]    f3_q;
    logic          pc_src_q;  // branch decision, presented at completion

    logic        is_store, is_load, is_mem, illegal, misal, bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, lane, load_fmt;

    assign in_ready  = (state == IDLE);
    assign stall_out = (state != IDLE);

    // A store takes priority when both mem_read and mem_write are set.
    assign is_store = crt_mem_in[1];
    assign is_load  = crt_mem_in[0] & ~crt_mem_in[1];
    assign is_mem   = crt_mem_in[0] | crt_mem_in[1];

    always_comb begin
        illegal = is_store ? (funct3_in > 3'b010)
                           : ((funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11));
        misal   = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
                  ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
        bad     = is_mem & (illegal | misal);
    end

    // The byte-lane mask is driven for loads too, so the bus sees which
    // bytes the load will use.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_result_in[1:0];
                st_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend it by size and sign.
    always_comb begin
        lane     = dmem_rdata >> {alu_q[1:0], 3'b000};
        load_fmt = dmem_rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_fmt = {24'h0, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_fmt = {16'h0, lane[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            alu_q         <= '0;
            f3_q          <= '0;
            pc_src_q      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            wb_valid      <= 1'b0;
            crt_wb_out    <= '0;
            wb_data       <= '0;
            rd_out        <= '0;
            pc_src_out    <= 1'b0;
            pc_target_out <= '0;
            misalign_out  <= 1'b0;
            bus_err_out   <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            wb_valid     <= 1'b0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            pc_src_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        crt_wb_out    <= crt_wb_in;
                        rd_out        <= rd_in;
                        pc_target_out <= pc_target_in;
                        pc_src_q      <= crt_mem_in[2] & zero_in;
                        alu_q         <= alu_result_in;
                        f3_q          <= funct3_in;
                        if (is_mem && !bad) begin
                            state      <= REQ;
                            cnt        <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {alu_result_in[31:2], 2'b00};
                            dmem_be    <= st_be;
                            dmem_wdata <= st_wdata;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_result_in;
                            misalign_out <= bad;
                            pc_src_out   <= crt_mem_in[2] & zero_in;
                        end
                    end
                end
                REQ: begin
                    // Any rvalid seen here is ignored.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        cnt      <= '0;
                        if (dmem_we) begin
                            state      <= IDLE;
                            wb_valid   <= 1'b1;
                            wb_data    <= alu_q;
                            pc_src_out <= pc_src_q;
                        end else begin
                            state <= WAIT_R;
                        end
                    end else if (cnt == TO_LAST) begin
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        wb_valid    <= 1'b1;
                        bus_err_out <= 1'b1;
                        wb_data     <= '0;
                        pc_src_out  <= pc_src_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        state      <= IDLE;
                        wb_valid   <= 1'b1;
                        wb_data    <= load_fmt;
                        pc_src_out <= pc_src_q;
                    end else if (cnt == TO_LAST) begin
                        state       <= IDLE;
                        wb_valid    <= 1'b1;
                        bus_err_out <= 1'b1;
                        wb_data     <= '0;
                        pc_src_out  <= pc_src_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the RV32I pipeline, and the consumer of the EXE stage outputs.
- Takes the EXE results (ALU result, store data, CRT_MEM/CRT_WB control, rd, zero, branch target).
- Runs load/store transactions on a req/gnt/rvalid data-memory bus, then presents registered MEM/WB results.
- Stalls upstream while a memory access is outstanding. Also resolves the branch decision (branch & zero).

Parameters:
- BUS_TIMEOUT, 255, max cycles spent in REQ or WAIT_R before the access is aborted with bus_err_out.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EXE result valid this cycle
- in_ready  out  1  stage can accept; 1 only in IDLE
- crt_mem_in  in  3  [0]=mem_read, [1]=mem_write, [2]=branch
- crt_wb_in  in  2  write-back control, passed through
- funct3_in  in  3  access size/sign (RV32I load/store encoding)
- alu_result_in  in  32  effective address or ALU result
- store_data_in  in  32  rs2 data for stores
- rd_in  in  5  destination register
- zero_in  in  1  ALU zero flag
- pc_target_in  in  32  branch target
- dmem_req  out  1  bus request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word address, {alu_result[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- wb_valid  out  1  one-cycle pulse, result valid
- crt_wb_out  out  2  registered crt_wb_in
- wb_data  out  32  formatted load data, or ALU result
- rd_out  out  5  registered rd
- pc_src_out  out  1  branch taken, valid with wb_valid
- pc_target_out  out  32  registered target
- misalign_out  out  1  misaligned or illegal funct3, valid with wb_valid
- bus_err_out  out  1  timeout abort, valid with wb_valid
- stall_out  out  1  combinational, = (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0, every registered output=0 including dmem_req and wb_valid.
  - Reset mid-transaction drops dmem_req immediately. The access is abandoned and no wb_valid is produced.
- FSM states: IDLE, REQ, WAIT_R. Accept occurs on in_valid && in_ready.
  - IDLE + accept, no memory op or misaligned/illegal: wb_valid=1 next cycle, latency 1.
    - wb_data = alu_result_in.
    - misalign_out set as applicable.
    - No bus activity.
  - IDLE + accept, valid memory op: goto REQ.
    - dmem_req=1 from the next cycle.
    - addr/we/be/wdata registered and held stable until gnt.
  - REQ + dmem_gnt, store: dmem_req=0, wb_valid pulse next cycle, goto IDLE.
  - REQ + dmem_gnt, load: dmem_req=0, goto WAIT_R.
  - dmem_rvalid asserted while in REQ is ignored; the bus guarantees rvalid arrives ≥1 cycle after gnt.
  - WAIT_R + dmem_rvalid: wb_data = formatted rdata, wb_valid pulse next cycle, goto IDLE.
  - Timeout: the counter resets on entry to REQ and on gnt. When it reaches BUS_TIMEOUT:
    - dmem_req=0;
    - wb_valid=1 with bus_err_out=1 and wb_data=0;
    - goto IDLE.
- mem_read and mem_write both set: performed as a store; mem_read is ignored.
- Store formatting:
  - SB (000): be = 1<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH (001): be = 0011 or 1100 by addr[1], wdata = {2{data[15:0]}}.
  - SW (010): be = 1111.
- Load formatting, using the lane selected by addr[1:0]:
  - LB=000 sign-extend byte, LBU=100 zero-extend byte.
  - LH=001 sign-extend half, LHU=101 zero-extend half.
  - LW=010 word.
- Misalign: halfword with addr[0]=1, or word with addr[1:0]≠00.
- Illegal funct3: loads 011/110/111, stores ≥011.
- pc_src_out = branch & zero_in, registered with the result. Branch-only ops complete with latency 1.
- crt_wb_out, rd_out, pc_target_out are captured at accept and held until the next accept.
- wb_valid, misalign_out, bus_err_out, pc_src_out are zero in every cycle without a completion.

Test Plan:
- Non-memory op (crt_mem=000, alu_result=0x1234) -> one cycle later wb_valid=1, wb_data=0x1234, no dmem_req.
- SB at addr 0x103, data 0xAABBCCDD, gnt after 2 cycles -> dmem_be=1000, wdata=0xDDDDDDDD, addr=0x100, req held 3 cycles, wb_valid then in_ready=1.
- LB at 0x202, rdata=0x0080FF00, rvalid 3 cycles after gnt -> wb_data=0xFFFFFF80; LBU -> 0x00000080; stall_out=1 throughout.
- LW at 0x302 -> misalign_out=1 with wb_valid next cycle, no bus request.
- Load never granted, BUS_TIMEOUT=4 -> dmem_req drops after 4 REQ cycles, bus_err_out=1, wb_data=0.
- Branch with zero=1, target 0x400 -> pc_src_out=1, pc_target_out=0x400. Separately: rst_n low during WAIT_R -> dmem_req=0 immediately and no wb_valid afterwards.
